// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker game: default geometry, FSM and direction
// encodings, column helpers and the row-slice convention of the row scanner.
package stacker_pkg;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_COLS        = 8;
  localparam int DEF_START_WIDTH = 3;

  // Helper functions take a zero-extended row of this width so they work for
  // any COLS up to this bound.
  localparam int MAX_COLS = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MOVE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_e;

  // RIGHT means increasing column index (pos counts up).
  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  // Number of lit columns in a row.
  function automatic int popcount_cols(input logic [MAX_COLS-1:0] v);
    int n;
    n = 0;
    for (int c = 0; c < MAX_COLS; c++) begin
      if (v[c]) n = n + 1;
    end
    return n;
  endfunction

  // Index of the lowest lit column; MAX_COLS when the row is empty.
  function automatic int ctz_cols(input logic [MAX_COLS-1:0] v);
    int n;
    n = MAX_COLS;
    for (int c = MAX_COLS - 1; c >= 0; c--) begin
      if (v[c]) n = c;
    end
    return n;
  endfunction

  // Row r occupies row_bits[row_lsb(r, cols) +: cols]; row 0 is the bottom.
  function automatic int row_lsb(input int r, input int cols);
    return r * cols;
  endfunction

endpackage

// File: rtl/stacker_block_mover.sv
// Sliding block of the current level: position, direction, width, the
// bounce at both edges of the matrix and the lit-column mask.
// Control priority: init > load > step.
module stacker_block_mover
  import stacker_pkg::*;
#(
  parameter  int COLS        = DEF_COLS,
  parameter  int START_WIDTH = DEF_START_WIDTH,
  localparam int PW          = $clog2(COLS) + 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            init,        // new game: pos 0, RIGHT, START_WIDTH
  input  logic            load,        // next level: take load_pos/load_width, keep dir
  input  logic            step,        // advance one column (bounce at the edges)
  input  logic [PW-1:0]   load_pos,
  input  logic [PW-1:0]   load_width,
  output logic [PW-1:0]   pos,
  output logic [PW-1:0]   width,
  output dir_e            dir,
  output logic [COLS-1:0] block
);

  logic [PW-1:0] pos_q, pos_d;
  logic [PW-1:0] width_q, width_d;
  dir_e          dir_q, dir_d;

  // Next position/direction; a step that would leave the matrix reverses
  // direction and moves the other way in the same tick. A full-width block
  // cannot move at all.
  always_comb begin
    pos_d   = pos_q;
    width_d = width_q;
    dir_d   = dir_q;
    if (init) begin
      pos_d   = '0;
      width_d = PW'(START_WIDTH);
      dir_d   = DIR_RIGHT;
    end else if (load) begin
      pos_d   = load_pos;
      width_d = load_width;
    end else if (step && (width_q != PW'(COLS))) begin
      if (dir_q == DIR_RIGHT) begin
        if ((pos_q + width_q) == PW'(COLS)) begin
          dir_d = DIR_LEFT;
          pos_d = pos_q - 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          dir_d = DIR_RIGHT;
          pos_d = pos_q + 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  // Block state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q   <= '0;
      width_q <= PW'(START_WIDTH);
      dir_q   <= DIR_RIGHT;
    end else begin
      pos_q   <= pos_d;
      width_q <= width_d;
      dir_q   <= dir_d;
    end
  end

  // Lit columns: ((1 << width) - 1) << pos.
  always_comb begin
    block = '0;
    for (int c = 0; c < COLS; c++) begin
      block[c] = (int'(pos_q) <= c) && (c < int'(pos_q) + int'(width_q));
    end
  end

  assign pos   = pos_q;
  assign width = width_q;
  assign dir   = dir_q;

endmodule

// File: rtl/stacker_game_core.sv
// Stacker game engine: game FSM, latched row register file and the
// registered bitmap consumed by the LED matrix row scanner.
module stacker_game_core
  import stacker_pkg::*;
#(
  parameter  int ROWS        = DEF_ROWS,
  parameter  int COLS        = DEF_COLS,
  parameter  int START_WIDTH = DEF_START_WIDTH,
  localparam int PW          = $clog2(COLS) + 1,
  localparam int LW          = $clog2(ROWS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 move_tick,
  input  logic                 freeze,
  output logic [ROWS*COLS-1:0] row_bits,
  output logic [LW-1:0]        level,
  output logic                 playing,
  output logic                 game_over,
  output logic                 win,
  output state_e               state_dbg
);

  // Inputs are single-cycle pulses sampled on posedge; there is no
  // backpressure. start is honoured only in IDLE/WIN/LOSE, freeze only in
  // MOVE, move_tick only in MOVE without a coincident freeze.

  state_e                   state_q, state_d;
  logic [LW-1:0]            level_q, level_d;
  logic [ROWS-1:0][COLS-1:0] rows_q, rows_d;
  logic [ROWS*COLS-1:0]     row_bits_q, row_bits_d;

  logic            mv_init, mv_load, mv_step;
  logic [PW-1:0]   mv_load_pos, mv_load_width;
  logic [PW-1:0]   mv_pos, mv_width;
  dir_e            mv_dir;
  logic [COLS-1:0] block;
  logic [COLS-1:0] below_row, new_row;

  stacker_block_mover #(
    .COLS        (COLS),
    .START_WIDTH (START_WIDTH)
  ) u_mover (
    .clk        (clk),
    .reset_n    (reset_n),
    .init       (mv_init),
    .load       (mv_load),
    .step       (mv_step),
    .load_pos   (mv_load_pos),
    .load_width (mv_load_width),
    .pos        (mv_pos),
    .width      (mv_width),
    .dir        (mv_dir),
    .block      (block)
  );

  // Surviving columns: the block trimmed against the level below (the floor
  // supports everything at level 0). Survivors are always contiguous.
  always_comb begin
    below_row = (level_q == '0) ? {COLS{1'b1}} : rows_q[level_q - 1'b1];
    new_row   = block & below_row;
  end

  // Game FSM next state, row file update and mover controls.
  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    rows_d        = rows_q;
    mv_init       = 1'b0;
    mv_load       = 1'b0;
    mv_step       = 1'b0;
    mv_load_pos   = '0;
    mv_load_width = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MOVE;
          level_d = '0;
          rows_d  = '0;
          mv_init = 1'b1;
        end
      end
      ST_MOVE: begin
        if (freeze) begin
          state_d = ST_CHECK;
        end else if (move_tick) begin
          mv_step = 1'b1;
        end
      end
      ST_CHECK: begin
        rows_d[level_q] = new_row;
        if (new_row == '0) begin
          state_d = ST_LOSE;
        end else if (level_q == LW'(ROWS - 1)) begin
          state_d = ST_WIN;
        end else begin
          state_d       = ST_MOVE;
          level_d       = level_q + 1'b1;
          mv_load       = 1'b1;
          mv_load_pos   = PW'(ctz_cols(MAX_COLS'(new_row)));
          mv_load_width = PW'(popcount_cols(MAX_COLS'(new_row)));
        end
      end
      ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d = ST_MOVE;
          level_d = '0;
          rows_d  = '0;
          mv_init = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bitmap for the scanner: latched rows, plus the moving block while in MOVE.
  always_comb begin
    row_bits_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_bits_d[row_lsb(r, COLS) +: COLS] = rows_q[r];
      if ((state_q == ST_MOVE) && (int'(level_q) == r)) begin
        row_bits_d[row_lsb(r, COLS) +: COLS] = rows_q[r] | block;
      end
    end
  end

  // FSM, row file and output bitmap registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      level_q    <= '0;
      rows_q     <= '0;
      row_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      rows_q     <= rows_d;
      row_bits_q <= row_bits_d;
    end
  end

  assign row_bits  = row_bits_q;
  assign level     = level_q;
  assign playing   = (state_q == ST_MOVE) || (state_q == ST_CHECK);
  assign game_over = (state_q == ST_WIN) || (state_q == ST_LOSE);
  assign win       = (state_q == ST_WIN);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stacker_game_core.sv
// Bench for stacker_game_core: directed game scenarios with hand-computed
// bitmaps, then random pulses checked every cycle against a game model.
module tb_stacker_game_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        move_tick = 1'b0;
  logic        freeze = 1'b0;
  logic [63:0] row_bits;
  logic [2:0]  level;
  logic        playing;
  logic        game_over;
  logic        win;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock / reset
  always #5 clk = ~clk;

  stacker_game_core dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .move_tick (move_tick),
    .freeze    (freeze),
    .row_bits  (row_bits),
    .level     (level),
    .playing   (playing),
    .game_over (game_over),
    .win       (win),
    .state_dbg (state_dbg)
  );

  // ---------------- game model
  localparam int M_IDLE  = 0;
  localparam int M_MOVE  = 1;
  localparam int M_CHECK = 2;
  localparam int M_WIN   = 3;
  localparam int M_LOSE  = 4;

  int          m_state;
  int          m_level;
  int          m_pos;
  int          m_width;
  int          m_dir;      // +1 right, -1 left
  logic [7:0]  m_rows[8];
  logic [63:0] m_rb;
  logic [63:0] exp_q[$];

  function automatic logic [7:0] m_block();
    int b;
    b = ((1 << m_width) - 1) << m_pos;
    return b[7:0];
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_level = 0;
    m_pos   = 0;
    m_width = 3;
    m_dir   = 1;
    for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
    m_rb = 64'h0;
  endtask

  task automatic model_begin_game();
    for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
    m_state = M_MOVE;
    m_level = 0;
    m_pos   = 0;
    m_width = 3;
    m_dir   = 1;
  endtask

  task automatic model_step(input logic s, input logic t, input logic f);
    logic [63:0] rb;
    logic [7:0]  nb;
    logic [7:0]  below;
    // Bitmap registered this cycle reflects the state before the update.
    rb = 64'h0;
    for (int r = 0; r < 8; r++) rb[r*8 +: 8] = m_rows[r];
    if (m_state == M_MOVE) rb[m_level*8 +: 8] = m_rows[m_level] | m_block();
    case (m_state)
      M_IDLE: if (s) model_begin_game();
      M_MOVE: begin
        if (f) begin
          m_state = M_CHECK;
        end else if (t && m_width < 8) begin
          if (m_pos + m_dir < 0 || m_pos + m_dir + m_width > 8) m_dir = -m_dir;
          m_pos = m_pos + m_dir;
        end
      end
      M_CHECK: begin
        below = (m_level == 0) ? 8'hFF : m_rows[(m_level + 7) % 8];
        nb = m_block() & below;
        m_rows[m_level] = nb;
        if (nb == 8'h00) begin
          m_state = M_LOSE;
        end else if (m_level == 7) begin
          m_state = M_WIN;
        end else begin
          m_level = m_level + 1;
          m_width = $countones(nb);
          m_pos = 8;
          for (int c = 7; c >= 0; c--) if (nb[c]) m_pos = c;
          m_state = M_MOVE;
        end
      end
      default: if (s) model_begin_game();
    endcase
    m_rb = rb;
  endtask

  // Model advances on every active edge from the inputs driven for that edge.
  always @(posedge clk) begin
    if (!reset_n) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step(start, move_tick, freeze);
      exp_q.push_back(m_rb);
    end
  end

  // ---------------- scoreboard
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare on the falling edge, between active edges.
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("row_bits", row_bits, e);
      chk("level", 64'(level), 64'(m_level));
      chk("playing", 64'(playing), 64'(m_state == M_MOVE || m_state == M_CHECK));
      chk("game_over", 64'(game_over), 64'(m_state == M_WIN || m_state == M_LOSE));
      chk("win", 64'(win), 64'(m_state == M_WIN));
    end
  end

  // ---------------- driver tasks
  // Called 1 time unit after an active edge; the pulses are seen by the next edge.
  task automatic cyc(input logic s, input logic t, input logic f);
    start = s;
    move_tick = t;
    freeze = f;
    @(posedge clk);
    #1;
    start = 1'b0;
    move_tick = 1'b0;
    freeze = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_row_bits"}, row_bits, 64'h0);
    chk({tag, "_level"}, 64'(level), 64'h0);
    chk({tag, "_playing"}, 64'(playing), 64'h0);
    chk({tag, "_game_over"}, 64'(game_over), 64'h0);
    chk({tag, "_win"}, 64'(win), 64'h0);
  endtask

  // ---------------- stimulus
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    reset_n = 1'b1;
    idle(2);
    chk("idle_dark", row_bits, 64'h0);

    // Slide right from pos 0, bounce at the right edge, come back left.
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_playing", 64'(playing), 64'h1);
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    idle(1);
    chk("pos3", 64'(row_bits[7:0]), 64'h38);
    cyc(1'b0, 1'b1, 1'b0); idle(1);
    chk("pos4", 64'(row_bits[7:0]), 64'h70);
    cyc(1'b0, 1'b1, 1'b0); idle(1);
    chk("pos5_edge", 64'(row_bits[7:0]), 64'hE0);
    cyc(1'b0, 1'b1, 1'b0); idle(1);
    chk("bounce", 64'(row_bits[7:0]), 64'h70);
    cyc(1'b0, 1'b1, 1'b0); idle(1);
    chk("moving_left", 64'(row_bits[7:0]), 64'h38);

    // Back to pos 0, latch level 0, then trim level 1 by one column.
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    idle(1);
    chk("pos0", 64'(row_bits[7:0]), 64'h07);
    cyc(1'b0, 1'b0, 1'b1); idle(1);
    chk("level1", 64'(level), 64'h1);
    cyc(1'b0, 1'b1, 1'b0); idle(1);
    chk("l1_block", 64'(row_bits[15:0]), 64'h0E07);
    cyc(1'b0, 1'b0, 1'b1); idle(2);
    chk("trimmed", row_bits, 64'h0000_0000_0006_0607);
    chk("level2", 64'(level), 64'h2);

    // Miss completely on level 2 -> LOSE, rows held, inputs ignored.
    repeat (5) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1); idle(1);
    chk("lose_over", 64'(game_over), 64'h1);
    chk("lose_win", 64'(win), 64'h0);
    idle(1);
    chk("lose_rows", row_bits, 64'h0000_0000_0000_0607);
    cyc(1'b0, 1'b1, 1'b1); idle(1);
    chk("lose_held", row_bits, 64'h0000_0000_0000_0607);
    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_playing", 64'(playing), 64'h1);
    idle(1);
    chk("restart_rows", row_bits, 64'h0000_0000_0000_0007);

    // Freeze aligned on all eight levels -> WIN.
    repeat (8) begin
      cyc(1'b0, 1'b0, 1'b1);
      idle(1);
    end
    chk("win_flag", 64'(win), 64'h1);
    chk("win_over", 64'(game_over), 64'h1);
    idle(1);
    chk("win_rows", row_bits, 64'h0707_0707_0707_0707);

    // Coincident freeze and tick latch the pre-tick position.
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    idle(2);
    chk("freeze_wins", 64'(row_bits[7:0]), 64'h1C);
    chk("freeze_level", 64'(level), 64'h1);

    // Asynchronous reset in the middle of a game.
    #2;
    reset_n = 1'b0;
    #1;
    chk_outputs_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Random pulses checked cycle by cycle against the model.
    repeat (3000) begin
      cyc($urandom_range(0, 99) < 4,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 7);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
